tanh_lut_server: RTL and testbench

TANH_LUT_SERVER -- requirements
Module: tanh_lut_server

---
 rtl/tanh_lut_server_if.sv | 25 ++
 rtl/tanh_lut_server.sv | 102 ++++++++++
 tb/tb_tanh_lut_server.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/tanh_lut_server_if.sv
// Lookup and table-load signal bundle for the tanh LUT server.
// Lookup signals are combinational; load signals use a valid/ready handshake.
// load_ready drops once the table is full; words offered then are refused and flagged.
interface tanh_lut_server_if;
  logic [11:0] lut_addr;
  logic        lut_sign;
  logic [15:0] lut_result;
  logic        load_start;
  logic        load_valid;
  logic [14:0] load_data;
  logic        load_ready;
  logic        table_ready;
  logic        load_overflow;
  logic [9:0]  load_count;

  modport slave (
    input  lut_addr, lut_sign, load_start, load_valid, load_data,
    output lut_result, load_ready, table_ready, load_overflow, load_count
  );

  modport master (
    output lut_addr, lut_sign, load_start, load_valid, load_data,
    input  lut_result, load_ready, table_ready, load_overflow, load_count
  );
endinterface

// File: rtl/tanh_lut_server.sv
// FP16 tanh lookup: bypass below the table, +/-1.0 above it, loaded table in between.
// Lookup latency 0 cycles (combinational); a load word is stored on the accepting edge.
// load_ready=0 once the table is full; words offered then are dropped and set load_overflow.
module tanh_lut_server #(
  parameter logic [11:0] BASE_ADDR = 12'h4E8,
  parameter logic [11:0] SAT_ADDR  = 12'h890
) (
  input logic              clk,
  input logic              rst_n,
  tanh_lut_server_if.slave srv
);

  localparam int          DEPTH    = int'(SAT_ADDR) - int'(BASE_ADDR);
  localparam int          IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [9:0]  LAST_CNT = 10'(DEPTH - 1);
  localparam logic [14:0] ONE_MAG  = 15'h3C00;
  localparam logic [15:0] QNAN     = 16'h7E00;

  typedef enum logic [1:0] {EMPTY, LOADING, READY} state_t;

  state_t           state_q, state_d;
  logic [9:0]       load_count_q, load_count_d;
  logic             overflow_q, overflow_d;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic [15:0]      result;

  // Table storage carries no reset; table_ready gates every read of it.
  logic [14:0] table_q [DEPTH];

  assign wr_idx = IDX_W'(load_count_q);
  assign rd_idx = IDX_W'(srv.lut_addr - BASE_ADDR);

  // Next-state logic: restart beats everything, then fill until the last entry lands.
  always_comb begin
    state_d      = state_q;
    load_count_d = load_count_q;
    overflow_d   = overflow_q;
    wr_en        = 1'b0;
    if (srv.load_start) begin
      state_d      = EMPTY;
      load_count_d = '0;
      overflow_d   = 1'b0;
    end else begin
      case (state_q)
        EMPTY, LOADING: begin
          if (srv.load_valid) begin
            wr_en        = 1'b1;
            load_count_d = load_count_q + 10'd1;
            state_d      = (load_count_q == LAST_CNT) ? READY : LOADING;
          end
        end
        READY: begin
          if (srv.load_valid) overflow_d = 1'b1;
        end
        default: begin
          state_d      = EMPTY;
          load_count_d = '0;
        end
      endcase
    end
  end

  // Control registers; reset abandons any load in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      load_count_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      load_count_q <= load_count_d;
      overflow_q   <= overflow_d;
    end
  end

  // Table write at the current fill index for each accepted word.
  always_ff @(posedge clk) begin
    if (wr_en) table_q[wr_idx] <= srv.load_data;
  end

  // Lookup mux: small inputs pass through (tanh(x) ~ x), large ones saturate,
  // table range reads the table once it is complete, otherwise quiet NaN.
  always_comb begin
    result = QNAN;
    if (srv.lut_addr < BASE_ADDR) begin
      result = {srv.lut_sign, srv.lut_addr, 3'b000};
    end else if (srv.lut_addr >= SAT_ADDR) begin
      result = {srv.lut_sign, ONE_MAG};
    end else if (state_q == READY) begin
      result = {srv.lut_sign, table_q[rd_idx]};
    end
  end

  assign srv.lut_result    = result;
  assign srv.load_ready    = (state_q != READY);
  assign srv.table_ready   = (state_q == READY);
  assign srv.load_overflow = overflow_q;
  assign srv.load_count    = load_count_q;

endmodule

// File: tb/tb_tanh_lut_server.sv
// Scoreboard bench for tanh_lut_server: stimulus queues expectations, monitor checks them.
// Checks happen on the falling edge, away from the edge that updates the DUT.
// Load words are driven back-to-back while load_ready is expected high.
module tb_tanh_lut_server;

  logic clk;
  logic rst_n;

  tanh_lut_server_if srv_if ();

  tanh_lut_server dut (
    .clk  (clk),
    .rst_n(rst_n),
    .srv  (srv_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: kind 0=lut_result 1=table_ready 2=load_overflow 3=load_count 4=load_ready
  string       exp_name[$];
  int          exp_kind[$];
  logic [15:0] exp_val[$];

  int   n_tests = 0;
  int   n_fail  = 0;
  logic chk_vld = 1'b0;

  string       m_name;
  int          m_kind;
  logic [15:0] m_exp;
  logic [15:0] m_act;

  // Monitor: pops every queued expectation while a probe is active.
  always @(negedge clk) begin
    if (chk_vld) begin
      while (exp_kind.size() > 0) begin
        m_name = exp_name.pop_front();
        m_kind = exp_kind.pop_front();
        m_exp  = exp_val.pop_front();
        case (m_kind)
          0:       m_act = srv_if.lut_result;
          1:       m_act = {15'd0, srv_if.table_ready};
          2:       m_act = {15'd0, srv_if.load_overflow};
          3:       m_act = {6'd0, srv_if.load_count};
          default: m_act = {15'd0, srv_if.load_ready};
        endcase
        n_tests++;
        if (m_act !== m_exp) begin
          n_fail++;
          $display("FAIL %s: got 0x%h, expected 0x%h", m_name, m_act, m_exp);
        end
      end
    end
  end

  task automatic expect_val(input string name, input int kind, input logic [15:0] val);
    exp_name.push_back(name);
    exp_kind.push_back(kind);
    exp_val.push_back(val);
  endtask

  task automatic probe();
    chk_vld = 1'b1;
    @(posedge clk);
    #1;
    chk_vld = 1'b0;
  endtask

  task automatic status(input string pfx, input logic tr, input logic ov,
                        input logic [9:0] cnt, input logic lr);
    expect_val({pfx, ".table_ready"}, 1, {15'd0, tr});
    expect_val({pfx, ".load_overflow"}, 2, {15'd0, ov});
    expect_val({pfx, ".load_count"}, 3, {6'd0, cnt});
    expect_val({pfx, ".load_ready"}, 4, {15'd0, lr});
  endtask

  task automatic lookup(input string name, input logic [11:0] a, input logic s,
                        input logic [15:0] e);
    srv_if.lut_addr = a;
    srv_if.lut_sign = s;
    expect_val(name, 0, e);
    probe();
  endtask

  // Drives indices first..last back-to-back, word = index + add.
  task automatic load_range(input int first, input int last, input int add);
    for (int i = first; i <= last; i++) begin
      srv_if.load_data  = 15'(i + add);
      srv_if.load_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    srv_if.load_valid = 1'b0;
  endtask

  // Watchdog: the run is a fixed sequence, so this only fires on a stuck simulation.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n             = 1'b0;
    srv_if.lut_addr   = '0;
    srv_if.lut_sign   = 1'b0;
    srv_if.load_start = 1'b0;
    srv_if.load_valid = 1'b0;
    srv_if.load_data  = '0;
    @(posedge clk);
    #1;

    // Checks while reset is held.
    status("rst", 1'b0, 1'b0, 10'd0, 1'b1);
    lookup("rst.nan", 12'h500, 1'b0, 16'h7E00);
    lookup("rst.nan_sign_ignored", 12'h500, 1'b1, 16'h7E00);
    lookup("rst.bypass", 12'h100, 1'b1, 16'h8800);
    lookup("rst.sat", 12'hFFF, 1'b0, 16'h3C00);
    lookup("rst.below_base", 12'h4E7, 1'b0, 16'h2738);
    lookup("rst.at_sat", 12'h890, 1'b1, 16'hBC00);

    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full load, word i = i + 1; stop one short to see table_ready still low.
    load_range(0, 934, 1);
    status("load935", 1'b0, 1'b0, 10'd935, 1'b1);
    lookup("load935.nan", 12'h4E8, 1'b1, 16'h7E00);
    status("hold", 1'b0, 1'b0, 10'd935, 1'b1);
    probe();
    load_range(935, 935, 1);
    status("full", 1'b1, 1'b0, 10'd936, 1'b0);
    lookup("full.first", 12'h4E8, 1'b1, 16'h8001);
    lookup("full.last", 12'h88F, 1'b0, 16'h03A8);
    lookup("full.mid", 12'h500, 1'b0, 16'h0019);
    lookup("full.bypass", 12'h100, 1'b1, 16'h8800);
    lookup("full.sat", 12'hFFF, 1'b0, 16'h3C00);
    lookup("full.below_base", 12'h4E7, 1'b0, 16'h2738);
    lookup("full.at_sat", 12'h890, 1'b1, 16'hBC00);

    // Offer a word while full: refused, flagged, table untouched.
    srv_if.load_data  = 15'h7FFF;
    srv_if.load_valid = 1'b1;
    @(posedge clk);
    #1;
    srv_if.load_valid = 1'b0;
    status("ovf", 1'b1, 1'b1, 10'd936, 1'b0);
    lookup("ovf.first", 12'h4E8, 1'b0, 16'h0001);
    status("ovf_sticky", 1'b1, 1'b1, 10'd936, 1'b0);
    lookup("ovf.last", 12'h88F, 1'b0, 16'h03A8);

    // Restart clears everything.
    srv_if.load_start = 1'b1;
    @(posedge clk);
    #1;
    srv_if.load_start = 1'b0;
    status("restart", 1'b0, 1'b0, 10'd0, 1'b1);
    lookup("restart.nan", 12'h4E8, 1'b1, 16'h7E00);

    // Partial load, then reset mid-load.
    load_range(0, 499, 7);
    status("part500", 1'b0, 1'b0, 10'd500, 1'b1);
    probe();
    rst_n = 1'b0;
    status("midrst", 1'b0, 1'b0, 10'd0, 1'b1);
    probe();
    rst_n = 1'b1;

    // Start and valid together: start wins, word discarded.
    srv_if.load_start = 1'b1;
    srv_if.load_valid = 1'b1;
    srv_if.load_data  = 15'h1234;
    @(posedge clk);
    #1;
    srv_if.load_start = 1'b0;
    srv_if.load_valid = 1'b0;
    status("start_wins", 1'b0, 1'b0, 10'd0, 1'b1);
    probe();

    // Full reload with word i = i + 100.
    load_range(0, 934, 100);
    status("reload935", 1'b0, 1'b0, 10'd935, 1'b1);
    lookup("reload935.nan", 12'h88F, 1'b0, 16'h7E00);
    load_range(935, 935, 100);
    status("reload", 1'b1, 1'b0, 10'd936, 1'b0);
    lookup("reload.first", 12'h4E8, 1'b0, 16'h0064);
    lookup("reload.last", 12'h88F, 1'b1, 16'h840B);

    @(posedge clk);
    #1;
    if (exp_kind.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_kind.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
